// File: rtl/bf_pkg.sv
// Shared definitions for the lamp-array and flasher blocks: behaviour codes,
// the default array width and the flasher state encodings.
package bf_pkg;

    localparam int LED_W_DEF = 16;

    // Behaviour code applied to the lamp array on each step.
    typedef enum logic [1:0] {
        LB_OFF  = 2'd0,
        LB_ON   = 2'd1,
        LB_HOLD = 2'd2,
        LB_CLR  = 2'd3
    } led_bhv_e;

    // Flasher sequencer states, kept here so both blocks share one encoding.
    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_ON   = 2'd1,
        FL_OFF  = 2'd2
    } flash_state_e;

endpackage

// File: rtl/step_prescaler.sv
// Step prescaler: counts 0..STEP_DIV-1 while enabled and flags the last
// phase as a tick. Holding en low freezes the phase; clr restarts it at 0.
module step_prescaler #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A width of 1 keeps STEP_DIV=1 legal; the phase then sits at 0 forever.
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);

    logic [PW-1:0] ph_q, ph_d;

    assign tick = en & (ph_q == LAST);

    // Next phase: clear wins, otherwise advance and wrap only while enabled.
    always_comb begin
        ph_d = ph_q;
        if (clr) begin
            ph_d = '0;
        end else if (en) begin
            ph_d = (ph_q == LAST) ? '0 : ph_q + PW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

endmodule

// File: rtl/led_array_driver.sv
// Lamp array driver: keeps a thermometer-coded lamp vector that grows or
// shrinks by one lamp per prescaler tick, with hold and clear behaviours,
// a registered step pulse and level-hit flags decoded from the lamp count.
module led_array_driver
    import bf_pkg::*;
#(
    parameter int LED_W    = LED_W_DEF,
    parameter int STEP_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 led_bhv,
    output logic [LED_W-1:0]           led,
    output logic [$clog2(LED_W+1)-1:0] lit_cnt,
    output logic                       step,
    output logic                       hit_0,
    output logic                       hit_5,
    output logic                       hit_10,
    output logic                       hit_15
);

    localparam int CW = $clog2(LED_W + 1);
    localparam logic [CW-1:0] FULL = CW'(LED_W);

    led_bhv_e        bhv;
    logic            tick;
    logic            presc_en;
    logic            presc_clr;
    logic [LED_W-1:0] led_q, led_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            step_q, step_d;

    assign bhv       = led_bhv_e'(led_bhv);
    assign presc_en  = (bhv == LB_ON) || (bhv == LB_OFF);
    assign presc_clr = (bhv == LB_CLR);

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // Next lamp state: clear overrides everything; a tick grows or shrinks
    // the thermometer by one lamp unless already saturated at that end.
    always_comb begin
        led_d  = led_q;
        cnt_d  = cnt_q;
        step_d = 1'b0;
        if (bhv == LB_CLR) begin
            led_d = '0;
            cnt_d = '0;
        end else if (tick) begin
            if ((bhv == LB_ON) && (cnt_q != FULL)) begin
                led_d  = {led_q[LED_W-2:0], 1'b1};
                cnt_d  = cnt_q + CW'(1);
                step_d = 1'b1;
            end else if ((bhv == LB_OFF) && (cnt_q != '0)) begin
                led_d  = {1'b0, led_q[LED_W-1:1]};
                cnt_d  = cnt_q - CW'(1);
                step_d = 1'b1;
            end
        end
    end

    // Lamp vector, lamp count and step pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= '0;
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            led_q  <= led_d;
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign led     = led_q;
    assign lit_cnt = cnt_q;
    assign step    = step_q;

    // Hit flags depend on the registered count only, so led_bhv never
    // reaches them combinationally. Levels above LED_W simply never hit.
    assign hit_0  = (cnt_q == '0);
    assign hit_5  = (32'(cnt_q) == 32'd6);
    assign hit_10 = (32'(cnt_q) == 32'd11);
    assign hit_15 = (32'(cnt_q) == 32'd16);

endmodule

// File: tb/tb_led_array_driver.sv
// Bench for led_array_driver: one instance with STEP_DIV=1 and one with
// STEP_DIV=4 share clock and reset; each is driven from a vector table.
module tb_led_array_driver;
    import bf_pkg::*;

    typedef struct {
        bit          sel;     // 0: STEP_DIV=1 instance, 1: STEP_DIV=4 instance
        logic [1:0]  bhv;
        int          n;
        logic [15:0] led;
        int          cnt;
        int          steps;
        logic [3:0]  hits;    // {hit_15, hit_10, hit_5, hit_0}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  bhv1, bhv4;
    logic [15:0] led1, led4;
    logic [4:0]  cnt1, cnt4;
    logic        step1, step4;
    logic        h1_0, h1_5, h1_10, h1_15;
    logic        h4_0, h4_5, h4_10, h4_15;

    int n_pass = 0;
    int n_tot  = 0;
    vec_t vt[19];

    always #5 clk = ~clk;

    led_array_driver #(.LED_W(16), .STEP_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .led_bhv(bhv1), .led(led1), .lit_cnt(cnt1),
        .step(step1), .hit_0(h1_0), .hit_5(h1_5), .hit_10(h1_10), .hit_15(h1_15)
    );

    led_array_driver #(.LED_W(16), .STEP_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .led_bhv(bhv4), .led(led4), .lit_cnt(cnt4),
        .step(step4), .hit_0(h4_0), .hit_5(h4_5), .hit_10(h4_10), .hit_15(h4_15)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic vec_t mk(bit s, logic [1:0] b, int n, logic [15:0] l,
                                int c, int st, logic [3:0] h);
        vec_t v;
        v.sel = s; v.bhv = b; v.n = n; v.led = l;
        v.cnt = c; v.steps = st; v.hits = h;
        return v;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        int   s;
        v = vt[idx];
        s = 0;
        if (v.sel) begin bhv4 = v.bhv; bhv1 = LB_HOLD; end
        else       begin bhv1 = v.bhv; bhv4 = LB_HOLD; end
        for (int c = 0; c < v.n; c++) begin
            @(posedge clk); #1;
            s += v.sel ? int'(step4) : int'(step1);
        end
        chk($sformatf("v%0d_led", idx), v.sel ? 32'(led4) : 32'(led1), 32'(v.led));
        chk($sformatf("v%0d_cnt", idx), v.sel ? 32'(cnt4) : 32'(cnt1), 32'(v.cnt));
        chk($sformatf("v%0d_steps", idx), 32'(s), 32'(v.steps));
        chk($sformatf("v%0d_hits", idx),
            v.sel ? 32'({h4_15, h4_10, h4_5, h4_0}) : 32'({h1_15, h1_10, h1_5, h1_0}),
            32'(v.hits));
    endtask

    initial begin
        // STEP_DIV=1 instance
        vt[0]  = mk(0, LB_OFF, 10, 16'h003F,  6, 10, 4'b0010);
        vt[1]  = mk(0, LB_CLR,  1, 16'h0000,  0,  0, 4'b0001);
        vt[2]  = mk(0, LB_ON,  20, 16'hFFFF, 16, 16, 4'b1000);
        vt[3]  = mk(0, LB_ON,   3, 16'hFFFF, 16,  0, 4'b1000);
        vt[4]  = mk(0, LB_OFF,  5, 16'h07FF, 11,  5, 4'b0100);
        vt[5]  = mk(0, LB_HOLD, 4, 16'h07FF, 11,  0, 4'b0100);
        vt[6]  = mk(0, LB_CLR,  1, 16'h0000,  0,  0, 4'b0001);
        vt[7]  = mk(0, LB_OFF,  3, 16'h0000,  0,  0, 4'b0001);
        vt[8]  = mk(0, LB_ON,   8, 16'h00FF,  8,  8, 4'b0000);
        // STEP_DIV=4 instance
        vt[9]  = mk(1, LB_ON,  12, 16'h0007,  3,  3, 4'b0000);
        vt[10] = mk(1, LB_ON,   2, 16'h0007,  3,  0, 4'b0000);
        vt[11] = mk(1, LB_HOLD,10, 16'h0007,  3,  0, 4'b0000);
        vt[12] = mk(1, LB_ON,   2, 16'h000F,  4,  1, 4'b0000);
        vt[13] = mk(1, LB_CLR,  1, 16'h0000,  0,  0, 4'b0001);
        vt[14] = mk(1, LB_ON,  32, 16'h00FF,  8,  8, 4'b0000);
        vt[15] = mk(1, LB_ON,   2, 16'h00FF,  8,  0, 4'b0000);
        // after the mid-prescale reset
        vt[16] = mk(1, LB_ON,   3, 16'h0000,  0,  0, 4'b0001);
        vt[17] = mk(1, LB_ON,   1, 16'h0001,  1,  1, 4'b0000);
        vt[18] = mk(0, LB_ON,   1, 16'h0001,  1,  1, 4'b0000);

        rst_n = 1'b0;
        bhv1  = LB_HOLD;
        bhv4  = LB_HOLD;
        #3;
        chk("rst_led",   32'(led1), 32'h0);
        chk("rst_cnt",   32'(cnt1), 32'h0);
        chk("rst_step",  32'(step1), 32'h0);
        chk("rst_hits",  32'({h1_15, h1_10, h1_5, h1_0}), 32'h1);
        chk("rst_hits4", 32'({h4_15, h4_10, h4_5, h4_0}), 32'h1);
        #9 rst_n = 1'b1;

        // Fill from empty one lamp per cycle, checking every intermediate state.
        bhv1 = LB_ON;
        for (int i = 1; i <= 16; i++) begin
            logic [31:0] exp_led;
            logic [3:0]  exp_h;
            exp_led = (32'd1 << i) - 32'd1;
            exp_h   = {i == 16, i == 11, i == 6, 1'b0};
            @(posedge clk); #1;
            chk($sformatf("fill%0d_led", i),  32'(led1), exp_led);
            chk($sformatf("fill%0d_cnt", i),  32'(cnt1), 32'(i));
            chk($sformatf("fill%0d_step", i), 32'(step1), 32'h1);
            chk($sformatf("fill%0d_hits", i), 32'({h1_15, h1_10, h1_5, h1_0}), 32'(exp_h));
        end

        for (int k = 0; k <= 15; k++) run_vec(k);

        // Asynchronous reset in the middle of a prescale period at 0x00FF.
        #1 rst_n = 1'b0;
        bhv1 = LB_HOLD;
        bhv4 = LB_HOLD;
        #1;
        chk("arst_led4",  32'(led4), 32'h0);
        chk("arst_cnt4",  32'(cnt4), 32'h0);
        chk("arst_step4", 32'(step4), 32'h0);
        chk("arst_hits4", 32'({h4_15, h4_10, h4_5, h4_0}), 32'h1);
        chk("arst_led1",  32'(led1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 16; k <= 18; k++) run_vec(k);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/led_array_driver.md
LED_ARRAY_DRIVER -- requirements
Module: led_array_driver

Interface
REQ-001 SHALL have parameter LED_W, default 16, number of lamps in the array.
REQ-002 SHALL have parameter STEP_DIV, default 1, clock cycles per lamp step (legal range 1..65535).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port led_bhv, input, 2, behaviour code: 0 = turn off one lamp, 1 = turn on one lamp, 2 = hold, 3 = clear.
REQ-006 SHALL have port led, output, LED_W, lamp vector; bit 0 is the first lamp lit.
REQ-007 SHALL have port lit_cnt, output, $clog2(LED_W+1), number of lamps lit.
REQ-008 SHALL have port step, output, 1, one-cycle pulse in the cycle after led changes due to a step.
REQ-009 SHALL have ports hit_0, hit_5, hit_10 and hit_15, each output, 1, asserted while lit_cnt equals 0, 6, 11 and 16 respectively.

Function
REQ-010 SHALL keep led a thermometer code at all times: led == (1 << lit_cnt) - 1.
REQ-011 SHALL generate an internal tick every STEP_DIV cycles from a prescaler counting 0..STEP_DIV-1; with STEP_DIV=1 the tick is asserted every cycle.
REQ-012 SHALL, on a tick with led_bhv=1 and lit_cnt<LED_W, register led <= {led[LED_W-2:0],1'b1} and lit_cnt <= lit_cnt+1.
REQ-013 SHALL, on a tick with led_bhv=0 and lit_cnt>0, register led <= {1'b0,led[LED_W-1:1]} and lit_cnt <= lit_cnt-1.
REQ-014 SHALL saturate: led_bhv=1 at lit_cnt=LED_W, or led_bhv=0 at lit_cnt=0, leaves led/lit_cnt unchanged and produces no step pulse.
REQ-015 SHALL hold led, lit_cnt and the prescaler phase while led_bhv=2; the prescaler does not advance.
REQ-016 SHALL, with led_bhv=3 in any cycle, clear led and lit_cnt to 0 and reset the prescaler to 0 on the next edge, independent of tick, with no step pulse.
REQ-017 SHALL assert step for exactly one cycle following every edge on which led changed under REQ-012/013, and never otherwise.
REQ-018 SHALL decode hit_* combinationally from registered lit_cnt only (no input-to-output combinational path from led_bhv).
REQ-019 SHALL apply a led_bhv change between 0 and 1 at the next tick, with no extra latency and no restart of the prescaler.
REQ-020 SHALL treat led_bhv sampled only at the clock edge; latency from tick edge to led update is one cycle.

Reset
REQ-021 SHALL, while rst_n=0, force led=0, lit_cnt=0, step=0, prescaler=0 asynchronously; hit_0=1, other hits=0.
REQ-022 SHALL resume counting from prescaler 0 on the first rising clk after rst_n deasserts; assertion mid-step discards the pending step.

Structure
REQ-023 SHALL take behaviour codes (LB_OFF=0, LB_ON=1, LB_HOLD=2, LB_CLR=3) and LED_W default from shared package bf_pkg, the same package that holds the flasher state encodings.
REQ-024 SHALL isolate the prescaler in one sub-module step_prescaler (inputs clk, rst_n, en, clr; output tick).
REQ-025 SHALL contain no latches; all registers reset by rst_n.

Verification
REQ-026 SHALL cover: reset, then led_bhv=1 for 16 cycles (STEP_DIV=1) -> led 0x0001,0x0003,...,0xFFFF; hit_5 at lit_cnt=6, hit_15 after 16th step.
REQ-027 SHALL cover: from 0xFFFF, led_bhv=0 for 10 cycles -> led=0x003F, lit_cnt=6, hit_5=1, 10 step pulses.
REQ-028 SHALL cover: led_bhv=1 held 20 cycles from 0 -> led saturates at 0xFFFF, step pulses stop after 16.
REQ-029 SHALL cover: STEP_DIV=4, led_bhv=1 for 12 cycles -> exactly 3 steps, led=0x0007; led_bhv=2 for 10 cycles inserted -> no change, phase preserved.
REQ-030 SHALL cover: led=0x07FF, led_bhv=3 one cycle -> led=0x0000, hit_0=1, no step pulse.
REQ-031 SHALL cover: rst_n low asynchronously mid-prescale at led=0x00FF -> led=0 immediately, before next clk edge.
